video_timing_sync_gen: RTL and testbench

- Parametrised successor to the fixed-mode video sync generator.
- Consumes an Avalon-ST RGB pixel stream and produces panel timing (HD, VD, DEN) plus registered pixel data.
- Generic in colour depth, horizontal/vertical timing and sync polarity.
- Adds frame lock to startofpacket, underflow and misalignment recovery, and error reporting.
- Sits between the frame reader / interpolation output stream and the display pins.

---
 rtl/video_timing_sync_gen.sv | 207 ++++++++++++++++++++
 tb/tb_video_timing_sync_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_sync_gen.sv
// video_timing_sync_gen
//   Panel timing generator that consumes an Avalon-ST RGB pixel stream and
//   produces HD/VD/DEN plus registered pixel data. The stream is locked to
//   the raster by its startofpacket. Loss of data (underflow) or an sop at
//   the wrong place (misalignment) blanks the output and reports the error.
//   The generator then waits for an sop at raster origin (0,0) to relock.
//
// Ports
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   in_ready/in_valid     Avalon-ST sink handshake
//   in_data               pixel {R,G,B}, COLOR_BITS per channel
//   in_startofpacket      first pixel of a frame
//   in_endofpacket        informational only, unused
//   in_empty              unused
//   rgb_out               registered pixel, zero outside the active area
//   hd, vd                sync outputs, asserted level SYNC_POL
//   den                   data enable
//   frame_start           one-cycle pulse with output pixel (0,0)
//   err_underflow         one-cycle pulse: no pixel at an active position
//   err_align             one-cycle pulse: sop misaligned with (0,0)
//   pattern_sel           (VIDEO_TIMING_PATTERN_EN only) show colour bars
//
// Build option
//   VIDEO_TIMING_PATTERN_EN: adds pattern_sel and an 8-bar colour test
//   pattern. While pattern_sel is high, the stream is stalled and the lock
//   state is frozen.

module video_timing_sync_gen #(
  parameter int COLOR_BITS = 8,
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    in_ready,
  input  logic                    in_valid,
  input  logic [3*COLOR_BITS-1:0] in_data,
  input  logic                    in_startofpacket,
  input  logic                    in_endofpacket,
  input  logic                    in_empty,
`ifdef VIDEO_TIMING_PATTERN_EN
  input  logic                    pattern_sel,
`endif
  output logic [3*COLOR_BITS-1:0] rgb_out,
  output logic                    hd,
  output logic                    vd,
  output logic                    den,
  output logic                    frame_start,
  output logic                    err_underflow,
  output logic                    err_align
);

  localparam int PW      = 3 * COLOR_BITS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, at_origin, hsync, vsync;
  logic          ready_c, show_c, underflow_c, align_c;
  logic [PW-1:0] pix_d;

  // endofpacket and empty carry no timing information.
  logic unused_inputs;
  assign unused_inputs = ^{in_endofpacket, in_empty};

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign hsync     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vsync     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

`ifdef VIDEO_TIMING_PATTERN_EN
  // Bar index from the horizontal position; narrow panels clamp to width 1.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [PW-1:0] bar_rgb;

  always_comb begin
    int bar;
    bar = int'(h_cnt) / BAR_W;
    if (bar > 7) bar = 7;
    // white, yellow, cyan, green, magenta, red, blue, black
    bar_rgb = {{COLOR_BITS{~bar[1]}}, {COLOR_BITS{~bar[2]}}, {COLOR_BITS{~bar[0]}}};
  end
`endif

  // Raster counters free-run regardless of lock state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge counter values, independent of statement order.
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    ready_c     = 1'b0;
    show_c      = 1'b0;
    underflow_c = 1'b0;
    align_c     = 1'b0;
    pix_d       = '0;

    case (state_q)
      SEARCH: begin
        if (in_valid) begin
          if (!in_startofpacket) begin
            ready_c = 1'b1;          // discard stray pixels before an sop
          end else if (at_origin) begin
            ready_c = 1'b1;
            show_c  = 1'b1;
            state_d = LOCKED;
          end
          // sop away from origin: hold it until the raster reaches (0,0)
        end
      end
      LOCKED: begin
        if (active) begin
          if (!in_valid) begin
            underflow_c = 1'b1;
            state_d     = SEARCH;
          end else if (in_startofpacket == at_origin) begin
            ready_c = 1'b1;          // sop exactly at origin, plain pixel elsewhere
            show_c  = 1'b1;
          end else begin
            align_c = 1'b1;          // frame too long or too short; keep sop pending
            state_d = SEARCH;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

`ifdef VIDEO_TIMING_PATTERN_EN
    if (pattern_sel) begin
      state_d     = state_q;
      ready_c     = 1'b0;
      show_c      = 1'b0;
      underflow_c = 1'b0;
      align_c     = 1'b0;
    end
`endif

    if (show_c) pix_d = in_data;
`ifdef VIDEO_TIMING_PATTERN_EN
    if (pattern_sel && active) pix_d = bar_rgb;
`endif
  end

  // Gating with reset_n keeps ready low during reset even though the reset
  // state (SEARCH) would otherwise accept non-sop pixels.
  assign in_ready = reset_n && ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      rgb_out       <= '0;
      den           <= 1'b0;
      hd            <= ~SYNC_POL;
      vd            <= ~SYNC_POL;
      frame_start   <= 1'b0;
      err_underflow <= 1'b0;
      err_align     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rgb_out       <= pix_d;
      den           <= active;
      hd            <= hsync ? SYNC_POL : ~SYNC_POL;
      vd            <= vsync ? SYNC_POL : ~SYNC_POL;
      frame_start   <= at_origin;
      err_underflow <= underflow_c;
      err_align     <= align_c;
    end
  end

endmodule

// File: tb/tb_video_timing_sync_gen.sv
// Self-checking bench for video_timing_sync_gen with a tiny raster:
// 8 clocks per line (4 active), 6 lines per frame (3 active), 48 clocks/frame.
// Each table record is one clock: stream inputs, expected in_ready, and
// expected registered outputs for that clock's raster position. Raster
// outputs (den/hd/vd/frame_start) are derived from the bench's own
// position counter.

module tb_video_timing_sync_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_ready;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        in_empty;
  logic [23:0] rgb_out;
  logic        hd, vd, den, frame_start, err_underflow, err_align;

  video_timing_sync_gen #(
    .COLOR_BITS(8),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .in_empty         (in_empty),
    .rgb_out          (rgb_out),
    .hd               (hd),
    .vd               (vd),
    .den              (den),
    .frame_start      (frame_start),
    .err_underflow    (err_underflow),
    .err_align        (err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        sop;
    logic [23:0] data;
    logic        exp_ready;
    logic [23:0] exp_rgb;
    logic        exp_uf;
    logic        exp_al;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input logic [23:0] b, input bit inc, input int i);
    return inc ? b + 24'(i) : b;
  endfunction

  task automatic add(input int n, input logic v, input logic s, input logic [23:0] d,
                     input logic r, input logic [23:0] e, input logic u, input logic a);
    vec_t t;
    t.valid = v; t.sop = s; t.data = d;
    t.exp_ready = r; t.exp_rgb = e; t.exp_uf = u; t.exp_al = a;
    for (int k = 0; k < n; k++) tbl.push_back(t);
  endtask

  // One locked 12-pixel frame; blanking holds the next pixel, the tail holds
  // the next frame's sop.
  task automatic add_frame(input logic [23:0] b, input bit inc, input logic [23:0] nxt);
    logic [23:0] p;
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < 4; x++) begin
        p = pix(b, inc, 4 * l + x);
        add(1, 1, (l == 0 && x == 0), p, 1, p, 0, 0);
      end
      if (l < 2) add(4, 1, 0, pix(b, inc, 4 * l + 4), 0, 24'h0, 0, 0);
    end
    add(28, 1, 1, nxt, 0, 24'h0, 0, 0);
  endtask

  task automatic apply(input vec_t v);
    int h, ln;
    h  = cyc % 8;
    ln = (cyc / 8) % 6;
    in_valid         = v.valid;
    in_startofpacket = v.sop;
    in_data          = v.data;
    #1;
    check("in_ready", 32'(in_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check("rgb_out",       32'(rgb_out),       32'(v.exp_rgb));
    check("den",           32'(den),           32'(h < 4 && ln < 3));
    check("hd",            32'(hd),            32'(!(h == 5 || h == 6)));
    check("vd",            32'(vd),            32'(ln != 4));
    check("frame_start",   32'(frame_start),   32'(h == 0 && ln == 0));
    check("err_underflow", 32'(err_underflow), 32'(v.exp_uf));
    check("err_align",     32'(err_align),     32'(v.exp_al));
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},      32'(in_ready),      32'h0);
    check({tag, " rgb_out"},       32'(rgb_out),       32'h0);
    check({tag, " den"},           32'(den),           32'h0);
    check({tag, " hd"},            32'(hd),            32'h1);
    check({tag, " vd"},            32'(vd),            32'h1);
    check({tag, " frame_start"},   32'(frame_start),   32'h0);
    check({tag, " err_underflow"}, 32'(err_underflow), 32'h0);
    check({tag, " err_align"},     32'(err_align),     32'h0);
  endtask

  initial begin
    int split;
    logic [23:0] b;

    // ---------------- stimulus table ----------------
    // Two idle frames after reset.
    add(96, 0, 0, 24'h0, 0, 24'h0, 0, 0);
    // Five junk pixels discarded, then sop held until (0,0).
    add(5, 1, 0, 24'hABCDEF, 1, 24'h0, 0, 0);
    add(43, 1, 1, 24'h00FF00, 0, 24'h0, 0, 0);
    // Two locked frames: constant green, then ramp data.
    add_frame(24'h00FF00, 0, 24'h102030);
    add_frame(24'h102030, 1, 24'h405060);
    // Underflow at pixel (2,1); rest of frame discarded, relock next frame.
    b = 24'h405060;
    for (int x = 0; x < 4; x++) add(1, 1, (x == 0), pix(b, 1, x), 1, pix(b, 1, x), 0, 0);
    add(4, 1, 0, pix(b, 1, 4), 0, 24'h0, 0, 0);
    add(1, 1, 0, pix(b, 1, 4), 1, pix(b, 1, 4), 0, 0);
    add(1, 1, 0, pix(b, 1, 5), 1, pix(b, 1, 5), 0, 0);
    add(1, 0, 0, 24'h0, 0, 24'h0, 1, 0);
    for (int i = 6; i < 12; i++) add(1, 1, 0, pix(b, 1, i), 1, 24'h0, 0, 0);
    add(31, 1, 1, 24'h708090, 0, 24'h0, 0, 0);
    add_frame(24'h708090, 1, 24'h0A0B0C);
    // Short frame of 11 pixels; next sop arrives at (3,2).
    b = 24'h0A0B0C;
    for (int x = 0; x < 4; x++) add(1, 1, (x == 0), pix(b, 1, x), 1, pix(b, 1, x), 0, 0);
    add(4, 1, 0, pix(b, 1, 4), 0, 24'h0, 0, 0);
    for (int x = 4; x < 8; x++) add(1, 1, 0, pix(b, 1, x), 1, pix(b, 1, x), 0, 0);
    add(4, 1, 0, pix(b, 1, 8), 0, 24'h0, 0, 0);
    for (int x = 8; x < 11; x++) add(1, 1, 0, pix(b, 1, x), 1, pix(b, 1, x), 0, 0);
    add(1, 1, 1, 24'hC0FFEE, 0, 24'h0, 0, 1);
    add(28, 1, 1, 24'hC0FFEE, 0, 24'h0, 0, 0);
    add_frame(24'hC0FFEE, 1, 24'h123456);
    // Start of a frame that gets reset mid-line at (1,1).
    b = 24'h123456;
    for (int x = 0; x < 4; x++) add(1, 1, (x == 0), pix(b, 1, x), 1, pix(b, 1, x), 0, 0);
    add(4, 1, 0, pix(b, 1, 4), 0, 24'h0, 0, 0);
    add(1, 1, 0, pix(b, 1, 4), 1, pix(b, 1, 4), 0, 0);
    split = tbl.size();
    // After reset release: sop presented at (0,0) locks immediately.
    add_frame(24'h55AA33, 1, 24'h0);

    // ---------------- initial reset ----------------
    in_valid         = 1'b1;
    in_startofpacket = 1'b0;
    in_data          = 24'h0;
    in_endofpacket   = 1'b0;
    in_empty         = 1'b0;
    reset_n          = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < split; i++) apply(tbl[i]);

    // ---------------- reset mid-line while LOCKED ----------------
    in_valid         = 1'b1;
    in_startofpacket = 1'b0;
    in_data          = pix(24'h123456, 1, 5);
    #1 check("pre-reset in_ready", 32'(in_ready), 32'h1);
    check("pre-reset den", 32'(den), 32'h1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("async");
    @(posedge clk);
    @(posedge clk);
    #1 check_reset_outputs("held");
    reset_n = 1'b1;
    cyc = 0;

    for (int i = split; i < tbl.size(); i++) apply(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
